// File: rtl/rns_div_pkg.sv
// Shared encodings and constants for the RNS back-end restoring divider.
package rns_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int          DIVIDEND_W_DEF = 12;
  localparam int          FACTOR_W_DEF   = 3;
  localparam logic [11:0] DBZ_QUOTIENT   = 12'hFFF;
  localparam int          ITER_LAST      = 11;

endpackage

// File: rtl/multiplier_3_3_6_BIT.sv
// Unsigned 3x3 -> 6-bit combinational product; the forward step of the RNS product path.
module multiplier_3_3_6_BIT (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [5:0] result
);

  assign result = {3'b000, a} * {3'b000, b};

endmodule

// File: rtl/divider_12_3_3_seq.sv
// Restoring divider: dividend / (factor_a*factor_b); result 14 edges after accept (2 on divide-by-zero).
// Accepts only in IDLE; result and out_valid are held until out_ready.
module divider_12_3_3_seq
  import rns_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int FACTOR_W   = FACTOR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIVIDEND_W-1:0]   dividend,
  input  logic [FACTOR_W-1:0]     factor_a,
  input  logic [FACTOR_W-1:0]     factor_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIVIDEND_W-1:0]   quotient,
  output logic [2*FACTOR_W-1:0]   remainder,
  output logic                    div_by_zero
);

  localparam int DW = 2 * FACTOR_W;
  localparam int CW = $clog2(DIVIDEND_W);

  div_state_t            state, state_nxt;
  logic [DIVIDEND_W-1:0] q_reg;
  logic [DW-1:0]         r_reg;
  logic [FACTOR_W-1:0]   fa_reg, fb_reg;
  logic [DW-1:0]         d_reg;
  logic [DW-1:0]         product;
  logic [CW-1:0]         cnt;
  logic                  dbz_reg;

  logic [DW:0]           shifted;
  logic [DW:0]           trial;
  logic                  trial_ok;

  multiplier_3_3_6_BIT u_mult (
    .a      (fa_reg),
    .b      (fb_reg),
    .result (product)
  );

  assign in_ready = (state == IDLE);

  // The restored remainder is always below D, so DW bits hold it; only the trial needs the extra bit.
  assign shifted  = {r_reg, q_reg[DIVIDEND_W-1]};
  assign trial_ok = (shifted >= {1'b0, d_reg});
  assign trial    = shifted - {1'b0, d_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = MULT;
      MULT: state_nxt = (product == '0) ? DONE : DIV;
      DIV:  if (cnt == CW'(ITER_LAST)) state_nxt = DONE;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= '0;
      r_reg       <= '0;
      fa_reg      <= '0;
      fb_reg      <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      dbz_reg     <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_reg   <= dividend;
            fa_reg  <= factor_a;
            fb_reg  <= factor_b;
            r_reg   <= '0;
            dbz_reg <= 1'b0;
          end
        end
        MULT: begin
          d_reg <= product;
          cnt   <= '0;
          if (product == '0) begin
            dbz_reg <= 1'b1;
            q_reg   <= DIVIDEND_W'(DBZ_QUOTIENT);
            r_reg   <= '0;
          end
        end
        DIV: begin
          if (trial_ok) begin
            r_reg <= trial[DW-1:0];
            q_reg <= {q_reg[DIVIDEND_W-2:0], 1'b1};
          end else begin
            r_reg <= shifted[DW-1:0];
            q_reg <= {q_reg[DIVIDEND_W-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          // First DONE cycle publishes the result; it then stays frozen until taken.
          if (!out_valid) begin
            out_valid   <= 1'b1;
            quotient    <= q_reg;
            remainder   <= r_reg;
            div_by_zero <= dbz_reg;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
